// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Round-robin arbiter sharing DMEM port B between N_REQ requesters.
//   One grant per cycle, grant is combinational (ready may depend on valid).
//   Read data comes back one cycle after acceptance, flagged only on the
//   winning requester's rsp_valid bit; rsp_rdata is mem_dout passed through.
//
//   Optional feature macro: DMEM_ARB_BURST_EN
//     When defined, the last granted requester keeps priority for up to
//     BURST_LEN consecutive grants while it stays valid.
//
// Ports
//   clk, nrst                 clock, synchronous active-low reset
//   req_valid/ready/we        per-requester handshake and direction
//   req_wstrb/addr/wdata      per-requester payload, flat slices
//   rsp_valid, rsp_rdata      read response (valid one-hot, shared data)
//   mem_en/we/wstrb/addr/din  memory port drive
//   mem_dout                  memory read data (1-cycle latency)
module dmem_port_arbiter #(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4
) (
  input  logic                             clk,
  input  logic                             nrst,
  input  logic [N_REQ-1:0]                 req_valid,
  output logic [N_REQ-1:0]                 req_ready,
  input  logic [N_REQ-1:0]                 req_we,
  input  logic [N_REQ*DATA_WIDTH/8-1:0]    req_wstrb,
  input  logic [N_REQ*ADDR_WIDTH-1:0]      req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0]      req_wdata,
  output logic [N_REQ-1:0]                 rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             mem_en,
  output logic                             mem_we,
  output logic [DATA_WIDTH/8-1:0]          mem_wstrb,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_din,
  input  logic [DATA_WIDTH-1:0]            mem_dout
);
  localparam int SW = DATA_WIDTH/8;
  localparam int PW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || BURST_LEN < 2 || BURST_LEN > 16 ||
      (DATA_WIDTH % 8) != 0) begin : g_bad_cfg
    $error("dmem_port_arbiter: parameter out of range");
  end

  // Flat payload buses viewed as per-requester packed arrays.
  logic [N_REQ-1:0][SW-1:0]         wstrb_a;
  logic [N_REQ-1:0][ADDR_WIDTH-1:0] addr_a;
  logic [N_REQ-1:0][DATA_WIDTH-1:0] wdata_a;
  assign wstrb_a = req_wstrb;
  assign addr_a  = req_addr;
  assign wdata_a = req_wdata;

  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    prio;
  logic [PW-1:0]    winner;
  logic [PW-1:0]    ptr_nxt;
  logic             any_valid;
  logic             accept;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] rd_pend;
  int               idx;

`ifdef DMEM_ARB_BURST_EN
  localparam int CW = $clog2(BURST_LEN+1);
  logic [PW-1:0] last_gnt;
  logic [CW-1:0] burst_cnt;
  logic [CW-1:0] cnt_nxt;
  // A burst is only "open" once it has at least one grant; a zero count
  // (after reset, an idle cycle or a completed burst) falls back to rr_ptr.
  logic          burst_hold;
  assign burst_hold = (burst_cnt != '0) && (burst_cnt < CW'(BURST_LEN)) &&
                      req_valid[last_gnt];
  assign cnt_nxt    = (winner == last_gnt) ? burst_cnt + 1'b1 : CW'(1);
`endif

  always_comb begin
    prio = rr_ptr;
`ifdef DMEM_ARB_BURST_EN
    if (burst_hold) prio = last_gnt;
`endif
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(prio) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any_valid && req_valid[idx]) begin
        any_valid = 1'b1;
        winner    = PW'(idx);
      end
    end
  end

  // Outputs are gated by nrst so nothing leaks to memory during reset.
  assign accept    = nrst && any_valid;
  assign gnt       = accept ? (N_REQ'(1) << winner) : '0;
  assign req_ready = gnt;
  assign ptr_nxt   = (winner == PW'(N_REQ-1)) ? '0 : winner + 1'b1;

  assign mem_en    = accept;
  assign mem_we    = accept && req_we[winner];
  assign mem_wstrb = accept ? wstrb_a[winner] : '0;
  assign mem_addr  = accept ? addr_a[winner]  : '0;
  assign mem_din   = accept ? wdata_a[winner] : '0;

  assign rsp_valid = nrst ? rd_pend : '0;
  assign rsp_rdata = mem_dout;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      rr_ptr  <= '0;
      rd_pend <= '0;
`ifdef DMEM_ARB_BURST_EN
      last_gnt  <= '0;
      burst_cnt <= '0;
`endif
    end else begin
      rd_pend <= (accept && !req_we[winner]) ? gnt : '0;
      if (accept) rr_ptr <= ptr_nxt;
`ifdef DMEM_ARB_BURST_EN
      if (accept) begin
        last_gnt  <= winner;
        burst_cnt <= (cnt_nxt == CW'(BURST_LEN)) ? '0 : cnt_nxt;
      end else begin
        burst_cnt <= '0;
      end
`endif
    end
  end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;
  localparam int NR = 2;
  localparam int AW = 11;
  localparam int DW = 32;
  localparam int SW = DW/8;
  localparam int BL = 4;

  logic              clk = 1'b0;
  logic              nrst;
  logic [NR-1:0]     req_valid, req_ready, req_we, rsp_valid;
  logic [NR*SW-1:0]  req_wstrb;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [DW-1:0]     rsp_rdata, mem_din, mem_dout;
  logic              mem_en, mem_we;
  logic [SW-1:0]     mem_wstrb;
  logic [AW-1:0]     mem_addr;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.N_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .nrst(nrst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_wstrb(req_wstrb), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // Environment memory: synchronous read, write-then-read ordering.
  logic [DW-1:0] env_mem [1<<AW];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < SW; b++)
          if (mem_wstrb[b]) env_mem[mem_addr][b*8 +: 8] <= mem_din[b*8 +: 8];
      end else begin
        mem_dout <= env_mem[mem_addr];
      end
    end
  end

  // Stimulus per requester
  logic          r_valid [NR];
  logic          r_we    [NR];
  logic [SW-1:0] r_wstrb [NR];
  logic [AW-1:0] r_addr  [NR];
  logic [DW-1:0] r_wdata [NR];

  // Reference model: memory image, priority pointer, outstanding read
  logic [DW-1:0] ref_mem [1<<AW];
  int            m_ptr, m_pend, m_last, m_cnt;
  logic [DW-1:0] m_pend_data;

  int total = 0;
  int bad   = 0;
  int last_w;
  logic [NR-1:0] cap_ready, cap_rsp_valid;
  logic [DW-1:0] cap_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
    int p;
    p = m_ptr;
`ifdef DMEM_ARB_BURST_EN
    if (m_cnt != 0 && m_cnt < BL && r_valid[m_last]) p = m_last;
`endif
    for (int k = 0; k < NR; k++)
      if (r_valid[(p+k)%NR]) return (p+k)%NR;
    return -1;
  endfunction

  task automatic idle_all();
    for (int i = 0; i < NR; i++) begin
      r_valid[i] = 1'b0; r_we[i] = 1'b0; r_wstrb[i] = '0;
      r_addr[i] = '0; r_wdata[i] = '0;
    end
  endtask

  // One clock: drive, sample at negedge, check against model, advance model.
  task automatic cyc();
    int w;
    logic [NR-1:0] e_rdy, e_rsp;
    logic [48:0]   e_mem;
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = r_valid[i];
      req_we[i]    = r_we[i];
      req_wstrb[i*SW +: SW] = r_wstrb[i];
      req_addr[i*AW +: AW]  = r_addr[i];
      req_wdata[i*DW +: DW] = r_wdata[i];
    end
    #4;
    w = nrst ? pick() : -1;
    e_rdy = '0;
    e_mem = '0;
    if (w >= 0) begin
      e_rdy[w] = 1'b1;
      e_mem = {1'b1, r_we[w], r_wstrb[w], r_addr[w], r_wdata[w]};
    end
    e_rsp = '0;
    if (nrst && m_pend >= 0) e_rsp[m_pend] = 1'b1;
    cap_ready = req_ready; cap_rsp_valid = rsp_valid; cap_rdata = rsp_rdata;
    chk("ready", 64'(req_ready), 64'(e_rdy));
    chk("mem_drive", 64'({mem_en, mem_we, mem_wstrb, mem_addr, mem_din}), 64'(e_mem));
    chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
    if (e_rsp != 0) chk("rsp_rdata", 64'(rsp_rdata), 64'(m_pend_data));
    last_w = w;
    if (!nrst) begin
      m_ptr = 0; m_pend = -1; m_last = 0; m_cnt = 0;
    end else begin
      m_pend = -1;
      if (w >= 0) begin
        if (r_we[w]) begin
          for (int b = 0; b < SW; b++)
            if (r_wstrb[w][b]) ref_mem[r_addr[w]][b*8 +: 8] = r_wdata[w][b*8 +: 8];
        end else begin
          m_pend = w; m_pend_data = ref_mem[r_addr[w]];
        end
        m_ptr = (w + 1) % NR;
        m_cnt = (w == m_last) ? m_cnt + 1 : 1;
        m_last = w;
        if (m_cnt == BL) m_cnt = 0;
      end else begin
        m_cnt = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  int exp_seq [10];
  int nrst_prev;

  initial begin
    for (int a = 0; a < (1<<AW); a++) begin env_mem[a] = '0; ref_mem[a] = '0; end
    mem_dout = '0;
    m_ptr = 0; m_pend = -1; m_last = 0; m_cnt = 0; m_pend_data = '0;
    idle_all();
    nrst = 1'b0;
    @(posedge clk); #1;

    // Reset held with both requesters valid: nothing granted.
    for (int i = 0; i < NR; i++) begin r_valid[i] = 1'b1; r_addr[i] = AW'(11'h100 + i); end
    repeat (3) begin
      cyc();
      chk("rst_ready", 64'(cap_ready), 64'd0);
    end
    nrst = 1'b1;
    cyc();
    chk("first_gnt", 64'(cap_ready), 64'b01);

    // Write by 0, read back by 1.
    idle_all();
    r_valid[0] = 1'b1; r_we[0] = 1'b1; r_wstrb[0] = 4'hF;
    r_addr[0] = 11'h005; r_wdata[0] = 32'hDEADBEEF;
    cyc();
    idle_all();
    r_valid[1] = 1'b1; r_addr[1] = 11'h005;
    cyc();
    idle_all();
    cyc();
    chk("rb_valid", 64'(cap_rsp_valid), 64'b10);
    chk("rb_data", 64'(cap_rdata), 64'hDEADBEEF);

    // Both requesters reading continuously from a fresh reset.
    nrst = 1'b0; cyc(); nrst = 1'b1;
`ifdef DMEM_ARB_BURST_EN
    exp_seq = '{0,0,0,0,1,1,1,1,0,0};
`else
    exp_seq = '{0,1,0,1,0,1,0,1,0,1};
`endif
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < NR; i++) begin
        r_valid[i] = 1'b1; r_we[i] = 1'b0; r_addr[i] = AW'(11'h020 + c);
      end
      cyc();
      chk("rr_seq", 64'(cap_ready), 64'(1 << exp_seq[c]));
    end
    idle_all();
    cyc();

    // Byte-strobe merge.
    r_valid[0] = 1'b1; r_we[0] = 1'b1; r_wstrb[0] = 4'hF;
    r_addr[0] = 11'h010; r_wdata[0] = 32'h12345678;
    cyc();
    r_wstrb[0] = 4'b0010; r_wdata[0] = 32'h0000AB00;
    cyc();
    r_we[0] = 1'b0; r_wstrb[0] = '0;
    cyc();
    idle_all();
    cyc();
    chk("strb_data", 64'(cap_rdata), 64'h1234AB78);
    chk("strb_valid", 64'(cap_rsp_valid), 64'b01);

    // Read in flight dropped by reset; restart from requester 0.
    r_valid[1] = 1'b1; r_addr[1] = 11'h010;
    cyc();
    idle_all();
    nrst = 1'b0;
    cyc();
    chk("rst_drop", 64'(cap_rsp_valid), 64'd0);
    nrst = 1'b1;
    cyc();
    chk("post_rst_rsp", 64'(cap_rsp_valid), 64'd0);
    for (int i = 0; i < NR; i++) begin r_valid[i] = 1'b1; r_addr[i] = AW'(11'h010); end
    cyc();
    chk("post_rst_gnt", 64'(cap_ready), 64'b01);

    // Randomized traffic; held-off requesters keep payload stable.
    nrst_prev = 1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!(r_valid[i] && last_w != i && nrst_prev == 1)) begin
          r_valid[i] = ($urandom_range(0, 3) != 0);
          r_we[i]    = $urandom_range(0, 1) == 1;
          r_wstrb[i] = SW'($urandom);
          r_addr[i]  = AW'($urandom_range(0, 15));
          r_wdata[i] = $urandom;
        end
      end
      nrst_prev = nrst;
      nrst = ($urandom_range(0, 39) != 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
